// File: rtl/ppt_match_if.sv
// Move/score bus between a rock-paper-scissors match controller and its environment.
interface ppt_match_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic [1:0]         j1;
  logic               j1_valid;
  logic [1:0]         j2;
  logic               j2_valid;
  logic               busy;
  logic               round_done;
  logic               j1_w;
  logic               j2_w;
  logic [SCORE_W-1:0] j1_score;
  logic [SCORE_W-1:0] j2_score;
  logic               match_done;
  logic [1:0]         winner;
  logic               err_invalid;

  modport master (
    output start, j1, j1_valid, j2, j2_valid,
    input  busy, round_done, j1_w, j2_w, j1_score, j2_score, match_done, winner, err_invalid
  );

  modport slave (
    input  start, j1, j1_valid, j2, j2_valid,
    output busy, round_done, j1_w, j2_w, j1_score, j2_score, match_done, winner, err_invalid
  );
endinterface

// File: rtl/ppt_match.sv
// Rock-paper-scissors match controller: move capture, round judging, scoring, match sequencing.
// Optional tie limit (draw after MAX_TIES consecutive ties) enabled by defining PPT_TIE_LIMIT_EN.
module ppt_match #(
  parameter int unsigned WINS_TO_MATCH = 2,
  parameter int unsigned SCORE_W       = 4,
  parameter int unsigned MAX_TIES      = 3
) (
  input logic        clk,
  input logic        rst_n,
  ppt_match_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_JUDGE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         m1_q, m1_d, m2_q, m2_d;
  logic               m1_v_q, m1_v_d, m2_v_q, m2_v_d;
  logic               busy_q, busy_d;
  logic               round_done_q, round_done_d;
  logic               j1_w_q, j1_w_d, j2_w_q, j2_w_d;
  logic [SCORE_W-1:0] j1_score_q, j1_score_d, j2_score_q, j2_score_d;
  logic               match_done_q, match_done_d;
  logic [1:0]         winner_q, winner_d;
  logic               err_q, err_d;
  logic               ok1_c, ok2_c;

`ifdef PPT_TIE_LIMIT_EN
  localparam int unsigned TIE_W = $clog2(MAX_TIES + 1);
  logic [TIE_W-1:0] tie_q, tie_d;
`else
  logic unused_max_ties;
  assign unused_max_ties = (MAX_TIES == 0);
`endif

  // True when move a beats move b
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) || (a == 2'b10 && b == 2'b01);
  endfunction

  assign ok1_c = bus.j1_valid && (bus.j1 != 2'b00);
  assign ok2_c = bus.j2_valid && (bus.j2 != 2'b00);

  always_comb begin
    state_d      = state_q;
    m1_d         = m1_q;
    m2_d         = m2_q;
    m1_v_d       = m1_v_q;
    m2_v_d       = m2_v_q;
    round_done_d = 1'b0;
    j1_w_d       = j1_w_q;
    j2_w_d       = j2_w_q;
    j1_score_d   = j1_score_q;
    j2_score_d   = j2_score_q;
    match_done_d = match_done_q;
    winner_d     = winner_q;
`ifdef PPT_TIE_LIMIT_EN
    tie_d        = tie_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          j1_score_d   = '0;
          j2_score_d   = '0;
          j1_w_d       = 1'b0;
          j2_w_d       = 1'b0;
          winner_d     = 2'b00;
          match_done_d = 1'b0;
`ifdef PPT_TIE_LIMIT_EN
          tie_d        = '0;
`endif
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // First legal strobe per player wins; later ones wait for the next round
        if (!m1_v_q && ok1_c) begin
          m1_d   = bus.j1;
          m1_v_d = 1'b1;
        end
        if (!m2_v_q && ok2_c) begin
          m2_d   = bus.j2;
          m2_v_d = 1'b1;
        end
        if (m1_v_d && m2_v_d) state_d = S_JUDGE;
      end
      S_JUDGE: begin
        round_done_d = 1'b1;
        m1_d         = 2'b00;
        m2_d         = 2'b00;
        m1_v_d       = 1'b0;
        m2_v_d       = 1'b0;
        state_d      = S_WAIT;
        if (beats(m1_q, m2_q)) begin
          j1_score_d = j1_score_q + SCORE_W'(1);
          j1_w_d     = 1'b1;
          j2_w_d     = 1'b0;
`ifdef PPT_TIE_LIMIT_EN
          tie_d      = '0;
`endif
          if (j1_score_d == SCORE_W'(WINS_TO_MATCH)) begin
            winner_d     = 2'b01;
            match_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end else if (beats(m2_q, m1_q)) begin
          j2_score_d = j2_score_q + SCORE_W'(1);
          j1_w_d     = 1'b0;
          j2_w_d     = 1'b1;
`ifdef PPT_TIE_LIMIT_EN
          tie_d      = '0;
`endif
          if (j2_score_d == SCORE_W'(WINS_TO_MATCH)) begin
            winner_d     = 2'b10;
            match_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end else begin
          j1_w_d = 1'b1;
          j2_w_d = 1'b1;
`ifdef PPT_TIE_LIMIT_EN
          tie_d  = tie_q + TIE_W'(1);
          if (tie_d == TIE_W'(MAX_TIES)) begin
            winner_d     = 2'b11;
            match_done_d = 1'b1;
            state_d      = S_DONE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_WAIT) || (state_d == S_JUDGE);
    err_d  = ((state_q == S_WAIT) || (state_q == S_JUDGE)) &&
             ((bus.j1_valid && bus.j1 == 2'b00) || (bus.j2_valid && bus.j2 == 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      m1_q         <= 2'b00;
      m2_q         <= 2'b00;
      m1_v_q       <= 1'b0;
      m2_v_q       <= 1'b0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      j1_w_q       <= 1'b0;
      j2_w_q       <= 1'b0;
      j1_score_q   <= '0;
      j2_score_q   <= '0;
      match_done_q <= 1'b0;
      winner_q     <= 2'b00;
      err_q        <= 1'b0;
`ifdef PPT_TIE_LIMIT_EN
      tie_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      m1_q         <= m1_d;
      m2_q         <= m2_d;
      m1_v_q       <= m1_v_d;
      m2_v_q       <= m2_v_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      j1_w_q       <= j1_w_d;
      j2_w_q       <= j2_w_d;
      j1_score_q   <= j1_score_d;
      j2_score_q   <= j2_score_d;
      match_done_q <= match_done_d;
      winner_q     <= winner_d;
      err_q        <= err_d;
`ifdef PPT_TIE_LIMIT_EN
      tie_q        <= tie_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.round_done  = round_done_q;
  assign bus.j1_w        = j1_w_q;
  assign bus.j2_w        = j2_w_q;
  assign bus.j1_score    = j1_score_q;
  assign bus.j2_score    = j2_score_q;
  assign bus.match_done  = match_done_q;
  assign bus.winner      = winner_q;
  assign bus.err_invalid = err_q;
endmodule

// File: doc/ppt_match.md
# ppt_match

Sequential rock-paper-scissors match controller. It accepts one move per player per round through independent valid strobes and judges each round. It keeps per-player scores and declares the match winner once a player reaches a parametrised number of round wins. It sits above the combinational round judge, wrapping it with move capture, scoring and match sequencing.

## Interface

Parameters:
- `WINS_TO_MATCH`, default 2: round wins required to take the match (2 gives best-of-3); legal range is 1 to 2^SCORE_W-1.
- `SCORE_W`, default 4: width of each score counter.
- `MAX_TIES`, default 3: consecutive ties that end the match as a draw. Used only when `PPT_TIE_LIMIT_EN` is defined.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begins a new match when sampled high in IDLE or DONE.
- `j1`, input, 2: player 1 move. 00 is invalid, 01 rock, 10 paper, 11 scissors.
- `j1_valid`, input, 1: `j1` is presented this cycle.
- `j2`, input, 2: player 2 move, same encoding as `j1`.
- `j2_valid`, input, 1: `j2` is presented this cycle.
- `busy`, output, 1: a match is in progress (WAIT or JUDGE).
- `round_done`, output, 1: one-cycle pulse when a round result is published.
- `j1_w`, output, 1: player 1 won or tied the last round (held).
- `j2_w`, output, 1: player 2 won or tied the last round (held). Both high means a tie.
- `j1_score`, output, SCORE_W: player 1 round wins in the current match.
- `j2_score`, output, SCORE_W: player 2 round wins in the current match.
- `match_done`, output, 1: the match has ended; held until `start` or reset.
- `winner`, output, 2: 00 none, 01 player 1, 10 player 2, 11 draw.
- `err_invalid`, output, 1: one-cycle pulse, a valid strobe carried move 00.

## Operation

- The FSM has four states: IDLE, WAIT, JUDGE and DONE.
- IDLE: `start` clears both scores, `j1_w`/`j2_w`, `winner`, `match_done` and the tie count, then the FSM goes to WAIT.
- WAIT: each player's move is latched independently on its first valid, non-00 strobe. Later strobes from a player already latched are ignored until the next round. When both moves are latched (same cycle or different cycles), the FSM goes to JUDGE.
- JUDGE lasts one cycle and applies the following rules.
  - Rock beats scissors, scissors beats paper, paper beats rock.
  - Winner's score increments; winner's `_w` goes to 1 and the loser's to 0.
  - On a tie, both `_w` go to 1, scores are unchanged and the tie count increments. Any decisive round clears the tie count.
  - `round_done` pulses and the latched moves are cleared.
  - If the incremented score equals `WINS_TO_MATCH`, `winner` is set to that player, `match_done` goes high and the FSM goes to DONE. Otherwise it returns to WAIT.
- DONE: all move strobes are ignored and outputs hold. `start` behaves as it does in IDLE.
- A strobe carrying 00 is never latched and pulses `err_invalid`, in any state except IDLE and DONE.
- `start` while `busy` is ignored.
- Scores cannot overflow, because the match ends at `WINS_TO_MATCH`.

## Timing

- Reset values: all outputs 0, FSM in IDLE, move latches and tie count cleared. Reset mid-match aborts the match immediately with no `round_done`.
- `start` sampled at edge k: `busy` = 1 from edge k. Moves are accepted from edge k+1 onward.
- The second move latched at edge k gives JUDGE during cycle k to k+1. At edge k+1, `round_done`, `_w`, scores, `winner` and `match_done` update together. `round_done` is high for exactly the cycle after edge k+1.
- Moves presented in the JUDGE cycle are ignored. A new round accepts moves from edge k+2.
- Minimum round period is 2 cycles (both valid in one cycle, then JUDGE).
- `err_invalid` is registered and is high in the cycle after the offending strobe.

## Configuration

- `PPT_TIE_LIMIT_EN` defined: when the tie count reaches `MAX_TIES` in JUDGE, `winner` = 11, `match_done` = 1 and the FSM goes to DONE. Scores are left unchanged.
- `PPT_TIE_LIMIT_EN` undefined: ties never end a match, there is no tie counter, and `winner` = 11 is unreachable.

## Test plan

- Reset then `start`; j1 = 01 and j2 = 11 together, twice → two `round_done` pulses, `j1_score` = 2, `winner` = 01, `match_done` = 1, `busy` = 0.
- `j1_valid` with 10 at cycle 3, `j2_valid` with 01 at cycle 7, a second `j1_valid` with 11 at cycle 5 → the later j1 strobe is ignored; the round judges paper vs rock, `j1_w` = 1, `j2_w` = 0.
- j1 = 00 valid → `err_invalid` pulses once and nothing is latched; a following j1 = 01 with j2 = 01 → tie, both `_w` = 1, scores stay 0/0.
- With `PPT_TIE_LIMIT_EN`, MAX_TIES = 3: three consecutive 10/10 rounds → `winner` = 11, `match_done` = 1. Without the macro → still `busy`, `winner` = 00.
- `rst_n` low for one cycle after one round (score 1/0) → all outputs 0 and FSM in IDLE; moves are ignored until `start`.
- In DONE, `start` → scores 0/0, `match_done` = 0, `busy` = 1; a further `start` while busy has no effect.
